lc3_int_ctrl: RTL and testbench
===============================

// Module: lc3_int_ctrl
// PURPOSE
//  Upstream interrupt controller for lc3_control. Latches edge-triggered
//  device requests, arbitrates by fixed per-source priority against the
//  current PSR priority, and drives INT plus a frozen vector/priority pair.
//  Control samples INT in FETCH0, consumes INTV/intPri in INT0 and pulses intAck.
// PARAMETERS
//  NUM_SRC  4                 number of device request lines (1..8)
//  SRC_PRI  12'b100_100_010_001  packed 3b priority per source, src i at [3i+2:3i]
//  SRC_VEC  32'h83828180      packed 8b vector per source, src i at [8i+7:8i]
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        synchronous reset, active-low
//  irq        in   NUM_SRC  device request levels; rising edge = request
//  irqEnWE    in   1        write strobe for enable mask
//  irqEnWData in   NUM_SRC  new enable mask
//  irqEn      out  NUM_SRC  enable mask readback
//  pending    out  NUM_SRC  latched pending requests
//  curPri     in   3        PSR[10:8], current processor priority
//  intAck     in   1        1-cycle acknowledge from control (INT0)
//  INT        out  1        interrupt request to control
//  INTV       out  8        vector of presented source
//  intPri     out  3        priority of presented source
// BEHAVIOUR
//  Reset (rst=0 at edge): irq_d=0, pending=0, irqEn=0, state=IDLE,
//   latched src/INTV/intPri=0; INT=0 while in reset.
//  Edge detect: rise[i] = irq[i] & ~irq_d[i]; irq_d<=irq every cycle.
//   pending[i] set on rise[i] regardless of irqEn; cleared only by ack of i.
//   Same-cycle rise and ack-clear on one source: set wins.
//  irqEnWE: irqEn<=irqEnWData next edge; does not touch pending.
//  Arbitration (comb): candidates = pending & irqEn with SRC_PRI[i] > curPri;
//   winner = highest SRC_PRI; ties -> lowest index. Priority-0 never wins.
//  FSM states:
//   IDLE:    INT=0. If winner exists: latch src, INTV=SRC_VEC[src],
//            intPri=SRC_PRI[src]; -> ASSERT.
//   ASSERT:  INT = irqEn[src] & (intPri > curPri) (comb). Latched values
//            frozen; no re-arbitration for higher arrivals.
//            intAck -> clear pending[src], -> SERVICE (ack beats withdrawal).
//            else if INT would be 0 (mask cleared / curPri raised) -> IDLE,
//            pending[src] kept.
//   SERVICE: INT=0 for exactly one cycle; -> IDLE.
//  intAck outside ASSERT: ignored, no state change.
//  Latency: irq high at edge t0 -> pending after t0 -> INT after t1 (2 clks).
//   After ack at edge ta, next INT no earlier than after ta+2.
//  INTV/intPri hold last latched value in SERVICE/IDLE until next latch.
//  rst=0 at any state (incl. ASSERT/SERVICE): full reset, request lost.
// TESTING
//  Reset: rst=0 2 clks, irq=4'hF -> INT=0,pending=0,irqEn=0; release with
//   irq held high -> no rise after reset since irq_d=0? rise seen: pending=F.
//  Single: irqEn=F, curPri=0, irq[2] 0->1 -> INT=1 2 clks later, INTV=8'h82,
//   intPri=4; intAck 1 clk -> pending[2]=0, INT=0 next 2 clks.
//  Tie: irq[2],irq[3] rise same clk -> INTV=82 first; after ack+SERVICE,
//   INTV=83, intPri=4.
//  Masking: curPri=4, irq[3] rise -> INT stays 0, pending[3]=1; curPri=3 ->
//   INT=1, INTV=83 2 clks later.
//  Withdraw: in ASSERT for src1, write irqEn=0 -> INT=0 same cycle, IDLE,
//   pending[1]=1; re-enable -> INT=1, INTV=81.
//  Ack/rise collide: irq[0] re-rises on intAck cycle for src0 -> pending[0]=1,
//   re-presented after SERVICE.

Source files
------------

// File: rtl/lc3_int_ctrl.sv
// Interrupt controller for lc3_control: edge-latched requests, fixed-priority arbitration
// against PSR priority, frozen vector/priority presentation until ack or withdrawal.
module lc3_int_ctrl #(
    parameter int                   NUM_SRC = 4,
    parameter logic [3*NUM_SRC-1:0] SRC_PRI = 12'b100_100_010_001,
    parameter logic [8*NUM_SRC-1:0] SRC_VEC = 32'h83828180
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               irqEnWE,
    input  logic [NUM_SRC-1:0] irqEnWData,
    output logic [NUM_SRC-1:0] irqEn,
    output logic [NUM_SRC-1:0] pending,
    input  logic [2:0]         curPri,
    input  logic               intAck,
    output logic               INT,
    output logic [7:0]         INTV,
    output logic [2:0]         intPri
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_SRC-1:0] r_irq_d;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_en;
    logic [SW-1:0]      r_src;
    logic [7:0]         r_vec;
    logic [2:0]         r_pri;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_clr_vec;
    logic               w_win_vld;
    logic [SW-1:0]      w_win_src;
    logic [2:0]         w_win_pri;
    logic               w_int;
    logic               w_ack_clr;
    logic               w_latch;

    assign w_rise = irq & ~r_irq_d;

    // Strictly-greater compare while scanning upward keeps the lowest index on ties.
    always_comb begin
        w_cand    = '0;
        w_win_vld = 1'b0;
        w_win_src = '0;
        w_win_pri = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_cand[i] = r_pend[i] & r_en[i] & (SRC_PRI[3*i +: 3] > curPri);
            if (w_cand[i] && (SRC_PRI[3*i +: 3] > w_win_pri)) begin
                w_win_vld = 1'b1;
                w_win_src = SW'(i);
                w_win_pri = SRC_PRI[3*i +: 3];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_int       = 1'b0;
        w_ack_clr   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                w_int = r_en[r_src] & (r_pri > curPri);
                if (intAck) begin
                    w_ack_clr   = 1'b1;
                    w_state_nxt = S_SERVICE;
                end else if (!w_int) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERVICE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign w_clr_vec = w_ack_clr ? (NUM_SRC'(1) << r_src) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_irq_d <= '0;
            r_pend  <= '0;
            r_en    <= '0;
            r_src   <= '0;
            r_vec   <= 8'd0;
            r_pri   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_irq_d <= irq;
            // A fresh rise on the acked source survives the clear.
            r_pend  <= (r_pend & ~w_clr_vec) | w_rise;
            if (irqEnWE) begin
                r_en <= irqEnWData;
            end
            if (w_latch) begin
                r_src <= w_win_src;
                r_vec <= SRC_VEC[8*w_win_src +: 8];
                r_pri <= w_win_pri;
            end
        end
    end

    assign INT     = w_int & rst;
    assign INTV    = r_vec;
    assign intPri  = r_pri;
    assign irqEn   = r_en;
    assign pending = r_pend;
endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Bench for lc3_int_ctrl: directed scenarios with literal expectations plus random traffic
// checked every cycle against a behavioural model of the controller.
module tb_lc3_int_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       irqEnWE;
    logic [3:0] irqEnWData;
    logic [3:0] irqEn;
    logic [3:0] pending;
    logic [2:0] curPri;
    logic       intAck;
    logic       INT;
    logic [7:0] INTV;
    logic [2:0] intPri;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    lc3_int_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq), .irqEnWE(irqEnWE), .irqEnWData(irqEnWData),
        .irqEn(irqEn), .pending(pending), .curPri(curPri), .intAck(intAck),
        .INT(INT), .INTV(INTV), .intPri(intPri)
    );

    // Model state: which source is being presented (-1 none) and a one-cycle cool-down.
    int         m_cur = -1;
    bit         m_svc = 0;
    logic [3:0] m_pend = 4'd0;
    logic [3:0] m_en = 4'd0;
    logic [3:0] m_prev = 4'd0;
    logic [7:0] m_vec = 8'd0;
    logic [2:0] m_pri = 3'd0;

    function automatic logic [2:0] pri_of(input int i);
        case (i)
            0:       return 3'd1;
            1:       return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] vec_of(input int i);
        return 8'h80 + 8'(i);
    endfunction

    function automatic bit exp_int();
        if (rst !== 1'b1 || m_cur < 0) return 1'b0;
        return m_en[m_cur] && (m_pri > curPri);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [3:0] rise;
        logic [3:0] np;
        logic [2:0] best;
        int         w;
        if (rst !== 1'b1) begin
            m_cur  = -1;
            m_svc  = 0;
            m_pend = 4'd0;
            m_en   = 4'd0;
            m_prev = 4'd0;
            m_vec  = 8'd0;
            m_pri  = 3'd0;
        end else begin
            rise = irq & ~m_prev;
            np   = m_pend;
            if (m_cur >= 0) begin
                if (intAck) begin
                    np[m_cur] = 1'b0;
                    m_svc     = 1;
                    m_cur     = -1;
                end else if (!exp_int()) begin
                    m_cur = -1;
                end
            end else if (m_svc) begin
                m_svc = 0;
            end else begin
                w    = -1;
                best = 3'd0;
                for (int i = 0; i < 4; i++) begin
                    if (m_pend[i] && m_en[i] && pri_of(i) > curPri && pri_of(i) > best) begin
                        w    = i;
                        best = pri_of(i);
                    end
                end
                if (w >= 0) begin
                    m_cur = w;
                    m_vec = vec_of(w);
                    m_pri = best;
                end
            end
            m_pend = np | rise;
            m_prev = irq;
            if (irqEnWE) m_en = irqEnWData;
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("INT", 32'(INT), 32'(exp_int()));
            cmp("INTV", 32'(INTV), 32'(m_vec));
            cmp("intPri", 32'(intPri), 32'(m_pri));
            cmp("pending", 32'(pending), 32'(m_pend));
            cmp("irqEn", 32'(irqEn), 32'(m_en));
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic ack();
        intAck = 1'b1;
        step();
        intAck = 1'b0;
    endtask

    initial begin
        rst = 1'b0; irq = 4'hF; irqEnWE = 1'b0; irqEnWData = 4'h0; curPri = 3'd0; intAck = 1'b0;
        step(2);
        cmp("rst_INT", 32'(INT), 32'd0);
        cmp("rst_pending", 32'(pending), 32'h0);
        cmp("rst_irqEn", 32'(irqEn), 32'h0);
        rst = 1'b1;
        step();
        cmp("rel_pending", 32'(pending), 32'hF);
        rst = 1'b0; irq = 4'h0;
        step();
        rst = 1'b1;
        step();

        irqEnWE = 1'b1; irqEnWData = 4'hF;
        step();
        irqEnWE = 1'b0;
        irq = 4'b0100;
        step();
        cmp("single_pend", 32'(pending), 32'h4);
        cmp("single_INT0", 32'(INT), 32'd0);
        step();
        cmp("single_INT", 32'(INT), 32'd1);
        cmp("single_INTV", 32'(INTV), 32'h82);
        cmp("single_pri", 32'(intPri), 32'd4);
        ack();
        cmp("single_clr", 32'(pending), 32'h0);
        cmp("single_svc", 32'(INT), 32'd0);
        step();
        cmp("single_idle", 32'(INT), 32'd0);

        irq = 4'h0;
        step();
        irq = 4'hC;
        step(2);
        cmp("tie_first", 32'(INTV), 32'h82);
        ack();
        cmp("tie_pend", 32'(pending), 32'h8);
        step(2);
        cmp("tie_INT", 32'(INT), 32'd1);
        cmp("tie_second", 32'(INTV), 32'h83);
        cmp("tie_pri", 32'(intPri), 32'd4);
        ack();
        step();

        irq = 4'h0; curPri = 3'd4;
        step();
        irq = 4'h8;
        step(3);
        cmp("mask_INT", 32'(INT), 32'd0);
        cmp("mask_pend", 32'(pending[3]), 32'd1);
        curPri = 3'd3;
        step(2);
        cmp("mask_INT1", 32'(INT), 32'd1);
        cmp("mask_INTV", 32'(INTV), 32'h83);
        ack();
        curPri = 3'd0;
        step();

        irq = 4'h0;
        step();
        irq = 4'h2;
        step(2);
        cmp("wd_INTV", 32'(INTV), 32'h81);
        irqEnWE = 1'b1; irqEnWData = 4'h0;
        step();
        cmp("wd_INT0", 32'(INT), 32'd0);
        irqEnWE = 1'b0;
        step();
        cmp("wd_pend", 32'(pending[1]), 32'd1);
        irqEnWE = 1'b1; irqEnWData = 4'hF;
        step();
        irqEnWE = 1'b0;
        step();
        cmp("wd_INT1", 32'(INT), 32'd1);
        cmp("wd_INTV1", 32'(INTV), 32'h81);
        ack();
        step();

        irq = 4'h0;
        step();
        irq = 4'h1;
        step(2);
        cmp("col_INT", 32'(INT), 32'd1);
        cmp("col_INTV", 32'(INTV), 32'h80);
        irq = 4'h0;
        step();
        intAck = 1'b1; irq = 4'h1;
        step();
        intAck = 1'b0;
        cmp("col_pend", 32'(pending[0]), 32'd1);
        cmp("col_svc", 32'(INT), 32'd0);
        step(2);
        cmp("col_re", 32'(INT), 32'd1);
        cmp("col_reV", 32'(INTV), 32'h80);
        ack();
        step();

        for (int c = 0; c < 3000; c++) begin
            irq        = 4'($urandom);
            irqEnWE    = ($urandom_range(0, 9) == 0);
            irqEnWData = 4'($urandom);
            if ($urandom_range(0, 9) == 0) curPri = 3'($urandom);
            intAck     = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 199) != 0);
            step();
        end
        rst = 1'b1; intAck = 1'b0; irqEnWE = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
